// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus-level constants for the I2C EEPROM target.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CTRL,
        S_CTRL_ACK,
        S_WADDR,
        S_WADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT
    } i2c_slv_state_t;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_pin_sync.sv
// i2c_pin_sync: 2-flop SCL/SDA synchroniser with registered SCL edge and START/STOP detection.
module i2c_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_q, sda_q;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q;

    // Idle bus is high, so the synchroniser resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_q      <= scl_sync_q[1];
            sda_q      <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_q;
            start_q    <= scl_sync_q[1] & scl_q & sda_q & ~sda_sync_q[1];
            stop_q     <= scl_sync_q[1] & scl_q & ~sda_q & sda_sync_q[1];
        end
    end

    assign sda_o      = sda_q;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: oversampling I2C target emulating a byte-addressed 24LC04-style EEPROM.
// Define I2C_SLAVE_WP_EN to add the wp write-protect input.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'b1010000,
    parameter int         MEM_AW    = 8,
    parameter int         PAGE_SIZE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
`ifdef I2C_SLAVE_WP_EN
    input  logic              wp,
`endif
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_strobe,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_byte
);

    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);

    i2c_slv_state_t    state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_byte_q, wr_byte_d;
    logic [7:0]        mem_q [0:(1<<MEM_AW)-1];

    logic              sda_s, scl_rise, scl_fall, start, stop, wr_block, byte_done, match;
    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] ptr_inc, ptr_page;

    i2c_pin_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

`ifdef I2C_SLAVE_WP_EN
    assign wr_block = wp;
`else
    assign wr_block = 1'b0;
`endif

    assign rx_byte   = {shift_q[6:0], sda_s};
    assign byte_done = cnt_q == 3'd7;
    assign match     = rx_byte[7:1] == DEV_ADDR;
    assign ptr_inc   = ptr_q + MEM_AW'(1);
    // Writes wrap inside the current page; reads use the full-array increment.
    assign ptr_page  = (ptr_q & ~PAGE_MASK) | (ptr_inc & PAGE_MASK);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_byte_d   = wr_byte_q;
        if (start) begin
            state_d  = S_CTRL;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                S_CTRL: begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d = match ? S_CTRL_ACK : S_IDLE;
                        busy_d  = match;
                        rw_d    = rx_byte[0];
                    end
                end
                S_WADDR: begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d = S_WADDR_ACK;
                        ptr_d   = MEM_AW'(rx_byte);
                    end
                end
                S_WR_DATA: begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d     = S_WR_ACK;
                        ptr_d       = ptr_page;
                        wr_strobe_d = ~wr_block;
                        wr_addr_d   = wr_block ? wr_addr_q : ptr_q;
                        wr_byte_d   = wr_block ? wr_byte_q : rx_byte;
                    end
                end
                S_RD_DATA: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = byte_done ? S_RD_ACK : S_RD_DATA;
                end
                S_RD_ACK: begin
                    state_d = sda_s == I2C_ACK ? S_RD_DATA : S_WAIT;
                    ptr_d   = sda_s == I2C_ACK ? ptr_inc : ptr_q;
                    shift_d = mem_q[ptr_inc];
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                // First fall starts the ACK bit, the second ends it and moves on.
                S_CTRL_ACK, S_WADDR_ACK, S_WR_ACK: begin
                    sda_oe_d = ~sda_oe_q;
                    if (sda_oe_q) begin
                        state_d = state_q != S_CTRL_ACK ? S_WR_DATA
                                : rw_q == I2C_RW_READ   ? S_RD_DATA : S_WADDR;
                        if (state_q == S_CTRL_ACK && rw_q == I2C_RW_READ) begin
                            shift_d  = mem_q[ptr_q];
                            sda_oe_d = ~mem_q[ptr_q][7];
                        end
                    end
                end
                S_RD_DATA: sda_oe_d = ~shift_q[7];
                S_RD_ACK:  sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= I2C_RW_WRITE;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_byte_q   <= wr_byte_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_strobe_q) mem_q[wr_addr_q] <= wr_byte_q;
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_byte   = wr_byte_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bit-banged I2C master with a write scoreboard and an EEPROM reference model.
module tb_i2c_eeprom_slave;

    localparam int Q = 12;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
`ifdef I2C_SLAVE_WP_EN
    logic wp = 1'b0;
`endif
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] wr_addr, wr_byte;
    wire        sda_line = sda_m & ~sda_oe;

    int         n_cmp = 0, n_err = 0;
    int         oe_cnt = 0, busy_cnt = 0;
    logic [7:0] model [256];
    wr_t        exp_q [$];

    i2c_eeprom_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
`ifdef I2C_SLAVE_WP_EN
        .wp       (wp),
`endif
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_byte  (wr_byte)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        oe_cnt   <= oe_cnt + int'(sda_oe);
        busy_cnt <= busy_cnt + int'(busy);
    end

    // Scoreboard: every committed byte must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got addr %02h data %02h, required no strobe", wr_addr, wr_byte);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_byte} !== {e.a, e.d}) begin
                    n_err++;
                    $display("FAIL wr_commit: got addr %02h data %02h, required addr %02h data %02h",
                             wr_addr, wr_byte, e.a, e.d);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q / 2);
        b = sda_line; tick(Q / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack_bit, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        n_cmp++;
        if (a !== exp_ack_bit) begin
            n_err++;
            $display("FAIL %s: ack bit got %b, required %b (byte %02h)", name, a, exp_ack_bit, b);
        end
    endtask

    task automatic send_data(input logic [7:0] a, input logic [7:0] d, input string name);
        exp_q.push_back('{a: a, d: d});
        model[a] = d;
        send_byte(d, 1'b0, name);
    endtask

    task automatic read_byte(input logic master_ack_bit, input logic [7:0] expv, input string name);
        logic [7:0] b;
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        write_bit(master_ack_bit);
        n_cmp++;
        if (b !== expv) begin
            n_err++;
            $display("FAIL %s: read got %02h, required %02h", name, b, expv);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected writes never committed, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if ({sda_oe, busy, wr_strobe, wr_addr, wr_byte} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got oe=%b busy=%b strobe=%b addr=%02h byte=%02h, required all 0",
                     sda_oe, busy, wr_strobe, wr_addr, wr_byte);
        end
    endtask

    task automatic test_write_page();
        i2c_start();
        send_byte(8'hA0, 1'b0, "wp_ctrl_ack");
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_addressed: got %b, required 1", busy);
        end
        send_byte(8'h00, 1'b0, "wp_waddr_ack");
        for (int i = 0; i < 4; i++) send_data(8'(i), 8'(100 + i), "wp_data_ack");
        i2c_stop();
        tick(4);
        check_drained("wp_drain");
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_stop: got %b, required 0", busy);
        end
    endtask

    task automatic test_random_read();
        logic b;
        i2c_start();
        send_byte(8'hA0, 1'b0, "rr_ctrl_w");
        send_byte(8'h02, 1'b0, "rr_waddr");
        i2c_start();
        send_byte(8'hA1, 1'b0, "rr_ctrl_r");
        read_byte(1'b0, model[8'h02], "rr_byte0");
        read_byte(1'b1, model[8'h03], "rr_byte1");
        n_cmp++;
        if (sda_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rr_release: sda_oe got %b, required 0", sda_oe);
        end
        read_bit(b);
        n_cmp++;
        if (b !== 1'b1) begin
            n_err++;
            $display("FAIL rr_wait_idle: sda got %b, required 1", b);
        end
        i2c_stop();
    endtask

    task automatic test_page_wrap();
        i2c_start();
        send_byte(8'hA0, 1'b0, "pg_ctrl");
        send_byte(8'h0E, 1'b0, "pg_waddr");
        send_data(8'h0E, 8'hAA, "pg_d0");
        send_data(8'h0F, 8'hBB, "pg_d1");
        send_data(8'h00, 8'hCC, "pg_d2");
        i2c_stop();
        tick(4);
        check_drained("pg_drain");
    endtask

    task automatic test_addr_mismatch();
        int oe0, busy0;
        tick(1);
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        i2c_start();
        send_byte(8'hA2, 1'b1, "mm_ctrl_nack");
        send_byte(8'h10, 1'b1, "mm_ignored0");
        send_byte(8'h77, 1'b1, "mm_ignored1");
        tick(2);
        n_cmp++;
        if (oe_cnt != oe0 || busy_cnt != busy0) begin
            n_err++;
            $display("FAIL mm_quiet: oe cycles %0d busy cycles %0d, required 0 and 0",
                     oe_cnt - oe0, busy_cnt - busy0);
        end
        i2c_start();
        send_byte(8'hA0, 1'b0, "mm_recover_ctrl");
        send_byte(8'h10, 1'b0, "mm_recover_waddr");
        send_data(8'h10, 8'h5A, "mm_recover_data");
        i2c_stop();
        tick(4);
        check_drained("mm_drain");
    endtask

    task automatic test_reset_mid();
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
        sda_m = 1'b1;
        tick(Q);
        n_cmp++;
        if ({sda_oe, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL rm_before: oe=%b busy=%b, required 1 1", sda_oe, busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sda_oe, busy, wr_strobe} !== 3'b000) begin
            n_err++;
            $display("FAIL rm_async: oe=%b busy=%b strobe=%b, required 0 0 0", sda_oe, busy, wr_strobe);
        end
        tick(2);
        scl_m = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(Q);
        i2c_start();
        send_byte(8'hA1, 1'b0, "rm_cur_ctrl");
        read_byte(1'b1, model[8'h00], "rm_ptr_reset");
        i2c_stop();
    endtask

    task automatic test_read_wrap();
        i2c_start();
        send_byte(8'hA0, 1'b0, "rw_ctrl");
        send_byte(8'hFF, 1'b0, "rw_waddr");
        send_data(8'hFF, 8'h3C, "rw_data");
        i2c_stop();
        tick(4);
        check_drained("rw_drain");
        i2c_start();
        send_byte(8'hA0, 1'b0, "rw_ctrl2");
        send_byte(8'hFF, 1'b0, "rw_waddr2");
        i2c_start();
        send_byte(8'hA1, 1'b0, "rw_ctrl_r");
        read_byte(1'b0, model[8'hFF], "rw_byte_ff");
        read_byte(1'b1, model[8'h00], "rw_byte_00");
        i2c_stop();
    endtask

`ifdef I2C_SLAVE_WP_EN
    task automatic test_write_protect();
        wp = 1'b1;
        i2c_start();
        send_byte(8'hA0, 1'b0, "prot_ctrl");
        send_byte(8'h10, 1'b0, "prot_waddr");
        send_byte(8'h55, 1'b0, "prot_data_ack");
        i2c_stop();
        wp = 1'b0;
        tick(4);
        i2c_start();
        send_byte(8'hA0, 1'b0, "prot_ctrl2");
        send_byte(8'h10, 1'b0, "prot_waddr2");
        i2c_start();
        send_byte(8'hA1, 1'b0, "prot_ctrl_r");
        read_byte(1'b1, model[8'h10], "prot_readback");
        i2c_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_write_page();
        test_random_read();
        test_page_wrap();
        test_addr_mismatch();
        test_reset_mid();
        test_read_wrap();
`ifdef I2C_SLAVE_WP_EN
        test_write_protect();
`endif
        tick(4);
        check_drained("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
